read_req_sched: RTL and testbench

- Two-requester scheduler for the shared RAM read port in front of the 2-entry read buffer.
- Arbitrates read requests round-robin and issues RAM reads.
- Uses credit accounting so that in-flight reads plus buffered entries never exceed buffer depth, which makes buffer overflow impossible.
- Tracks the requester ID (tag) of every read so the consumer knows who owns the buffer head entry.

---
 rtl/read_req_sched.sv | 161 ++++++++++++++++
 tb/tb_read_req_sched.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/read_req_sched.sv
`default_nettype none
// ============================================================================
//  Module      : read_req_sched
//  Description : Two-requester round-robin scheduler for the shared RAM read
//                port. Credit accounting keeps in-flight reads plus buffered
//                entries within the read buffer depth, and a tag FIFO tracks
//                which requester owns the buffer head entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module read_req_sched #(
    parameter int AW       = 8,
    parameter int RAM_LAT  = 2,
    parameter int RB_DEPTH = 2
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [1:0]                      req,
    input  logic [AW-1:0]                   addr0,
    input  logic [AW-1:0]                   addr1,
    output logic [1:0]                      gnt,
    output logic                            ram_rd,
    output logic [AW-1:0]                   ram_addr,
    input  logic                            ram_dvalid,
    input  logic                            rb_re,
    output logic                            rb_tag,
    output logic                            rb_empty,
    output logic [$clog2(RB_DEPTH+1)-1:0]   credits,
    output logic                            err
);

    localparam int c_CW = $clog2(RB_DEPTH + 1);
    localparam int c_PW = (RB_DEPTH > 1) ? $clog2(RB_DEPTH) : 1;

    logic [c_CW-1:0]    r_credits;
    logic               r_last;       // 1: requester 1 was granted most recently
    logic               r_ram_rd;
    logic [AW-1:0]      r_ram_addr;
    logic               r_issue_tag;  // tag travelling alongside ram_rd
    logic [RAM_LAT-1:0] r_pv;         // predicted-valid pipe
    logic [RAM_LAT-1:0] r_pt;         // predicted-tag pipe
    logic               r_fifo [RB_DEPTH];
    logic [c_PW-1:0]    r_rd_ptr;
    logic [c_PW-1:0]    r_wr_ptr;
    logic [c_CW-1:0]    r_count;
    logic               r_err;

    logic [1:0]         w_gnt;
    logic               w_grant;
    logic               w_win;
    logic               w_pred_v;
    logic               w_pred_tag;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;

    // Round-robin grant: only with a free credit; on contention the requester
    // that did not win last time goes first. Held low during reset.
    always_comb begin
        w_gnt = 2'b00;
        if (!RST && (r_credits != '0)) begin
            case (req)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11:   w_gnt = r_last ? 2'b01 : 2'b10;
                default: w_gnt = 2'b00;
            endcase
        end
    end

    assign w_grant    = |w_gnt;
    assign w_win      = w_gnt[1];
    assign w_pred_v   = r_pv[RAM_LAT-1];
    assign w_pred_tag = r_pt[RAM_LAT-1];
    assign w_empty    = (r_count == '0);
    // Only a read we actually issued may fill the buffer.
    assign w_push     = ram_dvalid & w_pred_v;
    // Popping an empty FIFO is a protocol error and is ignored, even when a
    // push lands in the same cycle.
    assign w_pop      = rb_re & ~w_empty;

    // Issue register: strobe, address and tag for the cycle after a grant.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ram_rd    <= 1'b0;
            r_ram_addr  <= '0;
            r_issue_tag <= 1'b0;
            r_last      <= 1'b1;
        end else begin
            r_ram_rd <= w_grant;
            if (w_grant) begin
                r_ram_addr  <= w_win ? addr1 : addr0;
                r_issue_tag <= w_win;
                r_last      <= w_win;
            end
        end
    end

    // Prediction pipe: valid/tag emerge exactly RAM_LAT cycles after ram_rd.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pv <= '0;
            r_pt <= '0;
        end else begin
            r_pv[0] <= r_ram_rd;
            r_pt[0] <= r_issue_tag;
            for (int i = 1; i < RAM_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pt[i] <= r_pt[i-1];
            end
        end
    end

    // Tag FIFO mirroring the read buffer contents.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < RB_DEPTH; i++) begin
                r_fifo[i] <= 1'b0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_pred_tag;
                r_wr_ptr <= (r_wr_ptr == c_PW'(RB_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PW'(RB_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
        end
    end

    // Credits: consumed by a grant, returned by a legal pop.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_credits <= c_CW'(RB_DEPTH);
        end else begin
            r_credits <= r_credits - c_CW'(w_grant) + c_CW'(w_pop);
        end
    end

    // Sticky error: unexpected/missing RAM data or a pop of an empty buffer.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_err <= 1'b0;
        end else if ((ram_dvalid != w_pred_v) || (rb_re && w_empty)) begin
            r_err <= 1'b1;
        end
    end

    assign gnt      = w_gnt;
    assign ram_rd   = r_ram_rd;
    assign ram_addr = r_ram_addr;
    assign rb_empty = w_empty;
    assign rb_tag   = w_empty ? 1'b0 : r_fifo[r_rd_ptr];
    assign credits  = r_credits;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_read_req_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_read_req_sched
//  Description : Self-checking bench for read_req_sched. A queue-based model
//                of credits, outstanding reads and buffer ownership predicts
//                every observable output; the bench also plays the RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_read_req_sched;

    localparam int AW       = 8;
    localparam int RAM_LAT  = 2;
    localparam int RB_DEPTH = 2;
    localparam int CW       = $clog2(RB_DEPTH + 1);

    logic           CLK = 1'b0;
    logic           RST = 1'b0;
    logic [1:0]     req = 2'b00;
    logic [AW-1:0]  addr0 = '0;
    logic [AW-1:0]  addr1 = '0;
    logic           ram_dvalid = 1'b0;
    logic           rb_re = 1'b0;
    logic [1:0]     gnt;
    logic           ram_rd;
    logic [AW-1:0]  ram_addr;
    logic           rb_tag;
    logic           rb_empty;
    logic [CW-1:0]  credits;
    logic           err;

    read_req_sched #(.AW(AW), .RAM_LAT(RAM_LAT), .RB_DEPTH(RB_DEPTH)) dut (
        .CLK(CLK), .RST(RST), .req(req), .addr0(addr0), .addr1(addr1),
        .gnt(gnt), .ram_rd(ram_rd), .ram_addr(ram_addr), .ram_dvalid(ram_dvalid),
        .rb_re(rb_re), .rb_tag(rb_tag), .rb_empty(rb_empty), .credits(credits),
        .err(err)
    );

    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    typedef struct { bit tag; int due; } infl_t;
    int            m_credits;
    bit            m_fifo[$];   // owners of buffered entries, head first
    infl_t         m_infl[$];   // outstanding reads with the cycle data is due
    bit            m_err;
    bit            m_last;      // requester that won most recently
    bit            m_ram_rd;
    logic [AW-1:0] m_ram_addr;
    int            cyc;
    bit            auto_ram;
    int            n_tests = 0;
    int            n_fail  = 0;

    function automatic logic [1:0] model_gnt();
        if (RST || m_credits == 0) return 2'b00;
        if (req == 2'b01) return 2'b01;
        if (req == 2'b10) return 2'b10;
        if (req == 2'b11) return (m_last == 1'b1) ? 2'b01 : 2'b10;
        return 2'b00;
    endfunction

    function automatic bit model_pred();
        return (m_infl.size() > 0) && (m_infl[0].due == cyc);
    endfunction

    task automatic model_reset();
        m_credits  = RB_DEPTH;
        m_fifo.delete();
        m_infl.delete();
        m_err      = 1'b0;
        m_last     = 1'b1;
        m_ram_rd   = 1'b0;
        m_ram_addr = '0;
        cyc        = 0;
    endtask

    // Advance model and DUT by one clock using the inputs currently driven.
    task automatic tick();
        logic [1:0] g;
        bit         pred;
        bit         pop_ok;
        infl_t      e;
        g      = model_gnt();
        pred   = model_pred();
        pop_ok = rb_re && (m_fifo.size() > 0);
        if (ram_dvalid !== pred) m_err = 1'b1;
        if (rb_re && m_fifo.size() == 0) m_err = 1'b1;
        if (pop_ok) void'(m_fifo.pop_front());
        if (pred) begin
            e = m_infl.pop_front();
            if (ram_dvalid) m_fifo.push_back(e.tag);
        end
        m_credits = m_credits - ((g != 2'b00) ? 1 : 0) + (pop_ok ? 1 : 0);
        m_ram_rd  = (g != 2'b00);
        if (g != 2'b00) begin
            m_last     = g[1];
            m_ram_addr = g[1] ? addr1 : addr0;
            e.tag      = g[1];
            e.due      = cyc + 1 + RAM_LAT;
            m_infl.push_back(e);
        end
        @(posedge CLK);
        #1;
        cyc++;
        ram_dvalid = auto_ram && model_pred();
    endtask

    task automatic do_reset();
        RST = 1'b1; req = 2'b00; rb_re = 1'b0; ram_dvalid = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        auto_ram = 1'b0;
        ram_dvalid = 1'b1;          // unexpected data to set err first
        req = 2'b11;
        #2; tick(); tick();
        ram_dvalid = 1'b0;
        #2;
        RST = 1'b1;                 // asynchronous, mid-cycle, requests still high
        #1;
        n_tests++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_async_gnt: got %b expected 00", gnt); end
        n_tests++; if (credits !== CW'(RB_DEPTH)) begin n_fail++; $display("FAIL reset_async_credits: got %0d expected %0d", credits, RB_DEPTH); end
        n_tests++; if (rb_empty !== 1'b1 || rb_tag !== 1'b0) begin n_fail++; $display("FAIL reset_async_fifo: got empty=%b tag=%b expected empty=1 tag=0", rb_empty, rb_tag); end
        n_tests++; if (err !== 1'b0 || ram_rd !== 1'b0 || ram_addr !== '0) begin n_fail++; $display("FAIL reset_async_regs: got err=%b rd=%b addr=%0h expected 0 0 0", err, ram_rd, ram_addr); end
        @(posedge CLK); #1;
        RST = 1'b0; req = 2'b00; model_reset();
        #2; tick(); #2;
        n_tests++; if (credits !== CW'(RB_DEPTH) || rb_empty !== 1'b1 || gnt !== 2'b00 || err !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got credits=%0d empty=%b gnt=%b err=%b expected 2 1 00 0", credits, rb_empty, gnt, err); end
    endtask

    task automatic test_single_read();
        logic [AW-1:0] a;
        do_reset();
        auto_ram = 1'b1;
        a = AW'($urandom);
        addr0 = a; addr1 = ~a; req = 2'b01;
        #2;
        n_tests++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL single_gnt: got %b expected 01", gnt); end
        tick(); req = 2'b00; #2;     // t1
        n_tests++; if (ram_rd !== 1'b1 || ram_addr !== a) begin n_fail++; $display("FAIL single_issue: got rd=%b addr=%0h expected rd=1 addr=%0h", ram_rd, ram_addr, a); end
        n_tests++; if (credits !== CW'(1)) begin n_fail++; $display("FAIL single_credit_take: got %0d expected 1", credits); end
        tick(); tick(); #2;          // t3, data returning now
        n_tests++; if (rb_empty !== 1'b1) begin n_fail++; $display("FAIL single_not_yet: got empty=%b expected 1", rb_empty); end
        tick(); #2;                  // t4
        n_tests++; if (rb_empty !== 1'b0 || rb_tag !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL single_buffered: got empty=%b tag=%b err=%b expected 0 0 0", rb_empty, rb_tag, err); end
        tick();                      // t5
        rb_re = 1'b1; #2; tick(); rb_re = 1'b0; #2;
        n_tests++; if (credits !== CW'(RB_DEPTH) || rb_empty !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL single_pop: got credits=%0d empty=%b err=%b expected 2 1 0", credits, rb_empty, err); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g [4];
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b00; exp_g[3] = 2'b00;
        do_reset();
        auto_ram = 1'b1;
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #2;
            n_tests++; if (gnt !== exp_g[i]) begin n_fail++; $display("FAIL rr_gnt%0d: got %b expected %b", i, gnt, exp_g[i]); end
            tick();
        end
        for (int k = 0; k < 10 && m_fifo.size() < 2; k++) tick();
        #2;
        n_tests++; if (credits !== CW'(0) || rb_tag !== 1'b0) begin n_fail++; $display("FAIL rr_full: got credits=%0d tag=%b expected 0 0", credits, rb_tag); end
        rb_re = 1'b1; #2;
        n_tests++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL rr_stalled: got %b expected 00", gnt); end
        tick(); rb_re = 1'b0; #2;
        n_tests++; if (gnt !== 2'b01 || rb_tag !== 1'b1) begin n_fail++; $display("FAIL rr_after_pop: got gnt=%b tag=%b expected 01 1", gnt, rb_tag); end
        tick(); req = 2'b00;
    endtask

    task automatic test_credit_stall();
        do_reset();
        auto_ram = 1'b1;
        addr1 = AW'($urandom);
        req = 2'b01; #2; tick();
        req = 2'b10; #2; tick();
        req = 2'b00;
        for (int k = 0; k < 10 && m_fifo.size() < 2; k++) tick();
        #2;
        n_tests++; if (credits !== CW'(0) || rb_empty !== 1'b0 || rb_tag !== 1'b0) begin n_fail++; $display("FAIL stall_full: got credits=%0d empty=%b tag=%b expected 0 0 0", credits, rb_empty, rb_tag); end
        rb_re = 1'b1; req = 2'b10; #2;
        n_tests++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL stall_gnt_blocked: got %b expected 00", gnt); end
        tick(); rb_re = 1'b0; #2;
        n_tests++; if (credits !== CW'(1) || gnt !== 2'b10 || rb_tag !== 1'b1) begin n_fail++; $display("FAIL stall_release: got credits=%0d gnt=%b tag=%b expected 1 10 1", credits, gnt, rb_tag); end
        tick(); req = 2'b00; #2;
        n_tests++; if (credits !== CW'(0) || ram_rd !== 1'b1 || ram_addr !== addr1) begin n_fail++; $display("FAIL stall_regrant: got credits=%0d rd=%b addr=%0h expected 0 1 %0h", credits, ram_rd, ram_addr, addr1); end
    endtask

    task automatic test_protocol_errors();
        do_reset();
        auto_ram = 1'b0;
        ram_dvalid = 1'b1; #2;
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL perr_early: got %b expected 0", err); end
        tick(); ram_dvalid = 1'b0; #2;
        n_tests++; if (err !== 1'b1 || rb_empty !== 1'b1 || credits !== CW'(RB_DEPTH)) begin n_fail++; $display("FAIL perr_unexpected: got err=%b empty=%b credits=%0d expected 1 1 2", err, rb_empty, credits); end
        rb_re = 1'b1; #2; tick(); rb_re = 1'b0; #2;
        n_tests++; if (err !== 1'b1 || credits !== CW'(RB_DEPTH) || rb_empty !== 1'b1) begin n_fail++; $display("FAIL perr_pop_empty: got err=%b credits=%0d empty=%b expected 1 2 1", err, credits, rb_empty); end
        // push and pop together into an empty buffer: pop rejected, push kept
        do_reset();
        auto_ram = 1'b1;
        req = 2'b01; #2; tick(); req = 2'b00;
        for (int k = 0; k < 10 && !model_pred(); k++) tick();
        rb_re = 1'b1; #2;
        n_tests++; if (rb_empty !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL perr_pre_collide: got empty=%b err=%b expected 1 0", rb_empty, err); end
        tick(); rb_re = 1'b0; #2;
        n_tests++; if (err !== 1'b1 || rb_empty !== 1'b0 || rb_tag !== 1'b0 || credits !== CW'(1)) begin n_fail++; $display("FAIL perr_collide: got err=%b empty=%b tag=%b credits=%0d expected 1 0 0 1", err, rb_empty, rb_tag, credits); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        auto_ram = 1'b0;
        req = 2'b01; #2; tick(); req = 2'b00;   // now t1
        RST = 1'b1; #2;
        n_tests++; if (ram_rd !== 1'b0 || credits !== CW'(RB_DEPTH)) begin n_fail++; $display("FAIL midflight_async: got rd=%b credits=%0d expected 0 2", ram_rd, credits); end
        @(posedge CLK); #1;
        RST = 1'b0; model_reset();
        #2; tick();                             // t3: stale data shows up
        ram_dvalid = 1'b1; #2; tick(); ram_dvalid = 1'b0; #2;
        n_tests++; if (err !== 1'b1 || credits !== CW'(RB_DEPTH) || rb_empty !== 1'b1) begin n_fail++; $display("FAIL midflight_stale: got err=%b credits=%0d empty=%b expected 1 2 1", err, credits, rb_empty); end
    endtask

    task automatic test_random();
        do_reset();
        auto_ram = 1'b1;
        for (int i = 0; i < 400; i++) begin
            req   = 2'($urandom_range(0, 3));
            addr0 = AW'($urandom);
            addr1 = AW'($urandom);
            rb_re = ($urandom_range(0, 2) == 0) && (m_fifo.size() > 0);
            #2;
            n_tests++; if (gnt !== model_gnt()) begin n_fail++; $display("FAIL rand_gnt c%0d: got %b expected %b", i, gnt, model_gnt()); end
            n_tests++; if (ram_rd !== m_ram_rd) begin n_fail++; $display("FAIL rand_rd c%0d: got %b expected %b", i, ram_rd, m_ram_rd); end
            if (m_ram_rd) begin
                n_tests++; if (ram_addr !== m_ram_addr) begin n_fail++; $display("FAIL rand_addr c%0d: got %0h expected %0h", i, ram_addr, m_ram_addr); end
            end
            n_tests++; if (credits !== CW'(m_credits)) begin n_fail++; $display("FAIL rand_credits c%0d: got %0d expected %0d", i, credits, m_credits); end
            n_tests++; if (rb_empty !== (m_fifo.size() == 0)) begin n_fail++; $display("FAIL rand_empty c%0d: got %b expected %b", i, rb_empty, m_fifo.size() == 0); end
            if (m_fifo.size() > 0) begin
                n_tests++; if (rb_tag !== m_fifo[0]) begin n_fail++; $display("FAIL rand_tag c%0d: got %b expected %b", i, rb_tag, m_fifo[0]); end
            end
            n_tests++; if (err !== m_err) begin n_fail++; $display("FAIL rand_err c%0d: got %b expected %b", i, err, m_err); end
            tick();
        end
        req = 2'b00; rb_re = 1'b0;
    endtask

    initial begin
        model_reset();
        auto_ram = 1'b0;
        #1;
        test_reset();
        test_single_read();
        test_round_robin();
        test_credit_stall();
        test_protocol_errors();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
